// File: rtl/alu_sched_if.sv
// Bundle of the two requester ports and the response port of the shared-ALU scheduler.
// The master side is the client/consumer; the slave side is the scheduler.
interface alu_sched_if;
  logic        r0_valid;
  logic        r0_ready;
  logic [31:0] r0_rs;
  logic [31:0] r0_rt;
  logic [3:0]  r0_op;

  logic        r1_valid;
  logic        r1_ready;
  logic [31:0] r1_rs;
  logic [31:0] r1_rt;
  logic [3:0]  r1_op;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rd;
  logic        resp_id;
  logic        resp_dz;
  logic        busy;

  modport master (
    output r0_valid, r0_rs, r0_rt, r0_op,
    input  r0_ready,
    output r1_valid, r1_rs, r1_rt, r1_op,
    input  r1_ready,
    output resp_ready,
    input  resp_valid, resp_rd, resp_id, resp_dz, busy
  );

  modport slave (
    input  r0_valid, r0_rs, r0_rt, r0_op,
    output r0_ready,
    input  r1_valid, r1_rs, r1_rt, r1_op,
    output r1_ready,
    input  resp_ready,
    output resp_valid, resp_rd, resp_id, resp_dz, busy
  );
endinterface

// File: rtl/alu_sched.sv
// Shared-ALU scheduler: round-robin arbitration of two requesters onto one 32-bit ALU,
// with op-dependent operand hold time (multicycle mul/div) and a registered valid/ready result.
module alu_sched #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input logic        clk,
  input logic        reset,
  alu_sched_if.slave bus
);

  localparam logic [3:0] OP_ADD   = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0001;
  localparam logic [3:0] MUL_HOLD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_HOLD = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        last_grant;
  logic [31:0] op_rs;
  logic [31:0] op_rt;
  logic [3:0]  op_code;
  logic        op_id;
  logic        op_dz;

  logic        grant;
  logic        accept;
  logic [31:0] sel_rs;
  logic [31:0] sel_rt;
  logic [3:0]  sel_op;
  logic        sel_dz;
  logic [3:0]  sel_hold;
  logic [31:0] alu_y;

  // Round-robin only matters on a tie; otherwise the single valid requester wins.
  always_comb begin
    if (bus.r0_valid && bus.r1_valid) grant = ~last_grant;
    else                              grant = bus.r1_valid;
  end

  assign accept       = (state == IDLE) && !reset && (bus.r0_valid || bus.r1_valid);
  assign bus.r0_ready = (state == IDLE) && !reset && bus.r0_valid && !grant;
  assign bus.r1_ready = (state == IDLE) && !reset && bus.r1_valid && grant;
  assign bus.busy     = (state != IDLE);

  assign sel_rs = grant ? bus.r1_rs : bus.r0_rs;
  assign sel_rt = grant ? bus.r1_rt : bus.r0_rt;
  assign sel_op = grant ? bus.r1_op : bus.r0_op;
  assign sel_dz = (sel_op == OP_DIV) && (sel_rt == 32'd0);

  // Divide by zero skips the long hold since the ALU result is discarded anyway.
  always_comb begin
    case (sel_op)
      OP_MUL:  sel_hold = MUL_HOLD;
      OP_DIV:  sel_hold = sel_dz ? 4'd1 : DIV_HOLD;
      default: sel_hold = 4'd1;
    endcase
  end

  always_comb begin
    case (op_code)
      OP_ADD:  alu_y = op_rs + op_rt;
      OP_SUB:  alu_y = op_rs - op_rt;
      OP_MUL:  alu_y = op_rs * op_rt;
      OP_DIV:  alu_y = (op_rt == 32'd0) ? 32'hFFFF_FFFF : op_rs / op_rt;
      default: alu_y = op_rs + op_rt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      last_grant     <= 1'b1;
      op_rs          <= 32'd0;
      op_rt          <= 32'd0;
      op_code        <= 4'd0;
      op_id          <= 1'b0;
      op_dz          <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rd    <= 32'd0;
      bus.resp_id    <= 1'b0;
      bus.resp_dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_rs      <= sel_rs;
            op_rt      <= sel_rt;
            op_code    <= sel_op;
            op_id      <= grant;
            op_dz      <= sel_dz;
            cnt        <= sel_hold - 4'd1;
            last_grant <= grant;
            state      <= EXEC;
          end
        end
        // Operand registers stay frozen here so mul/div can be timed as multicycle paths.
        EXEC: begin
          if (cnt == 4'd0) begin
            bus.resp_rd    <= op_dz ? 32'hFFFF_FFFF : alu_y;
            bus.resp_id    <= op_id;
            bus.resp_dz    <= op_dz;
            bus.resp_valid <= 1'b1;
            state          <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched with MUL_CYCLES=2 and DIV_CYCLES=4.
// Latency "lat" counts clock edges from the handshake edge to resp_valid rising (equals hold_cycles).
module tb_alu_sched;

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_sched_if bus ();

  alu_sched #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bus.r0_valid   = 1'b0;
    bus.r1_valid   = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (n) tick();
  endtask

  // Issues one op and waits for its response; lat is -1 if any wait expired.
  task automatic run_op(input bit id, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, output int lat, output logic [31:0] rd,
                        output logic rid, output logic rdz);
    int n;
    bit ok;
    ok = 1'b1;
    if (id) begin
      bus.r1_valid = 1'b1; bus.r1_op = op; bus.r1_rs = rs; bus.r1_rt = rt;
    end else begin
      bus.r0_valid = 1'b1; bus.r0_op = op; bus.r0_rs = rs; bus.r0_rt = rt;
    end
    #1;
    n = 0;
    while (!(id ? bus.r1_ready : bus.r0_ready) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) ok = 1'b0;
    tick();
    if (id) bus.r1_valid = 1'b0;
    else    bus.r0_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 40) begin
      tick();
      n++;
    end
    lat = (ok && bus.resp_valid) ? n : -1;
    rd  = bus.resp_rd;
    rid = bus.resp_id;
    rdz = bus.resp_dz;
  endtask

  task automatic test_reset();
    bus.r0_valid = 1'b1; bus.r0_op = OP_ADD; bus.r0_rs = 32'd1; bus.r0_rt = 32'd1;
    bus.r1_valid = 1'b0; bus.r1_op = OP_ADD; bus.r1_rs = 32'd0; bus.r1_rt = 32'd0;
    bus.resp_ready = 1'b1;
    reset = 1'b1;
    repeat (2) begin
      tick();
      checks++; if (bus.r0_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_r0_ready got %b expected 0", bus.r0_ready); end
      checks++; if (bus.r1_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_r1_ready got %b expected 0", bus.r1_ready); end
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_valid got %b expected 0", bus.resp_valid); end
      checks++; if (bus.resp_rd !== 32'd0) begin errors++; $display("[TB] FAIL rst_resp_rd got %h expected 0", bus.resp_rd); end
      checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_id got %b expected 0", bus.resp_id); end
      checks++; if (bus.resp_dz !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_dz got %b expected 0", bus.resp_dz); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b expected 0", bus.busy); end
    end
    bus.r0_valid = 1'b0;
    reset = 1'b0;
    repeat (3) begin
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b expected 0", bus.busy); end
    end
  endtask

  task automatic test_add_sub();
    int lat; logic [31:0] rd; logic rid, rdz;
    idle_cycles(2);
    run_op(1'b0, OP_ADD, 32'd5, 32'd7, lat, rd, rid, rdz);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL add_lat got %0d expected 1", lat); end
    checks++; if (rd !== 32'd12) begin errors++; $display("[TB] FAIL add_rd got %h expected %h", rd, 32'd12); end
    checks++; if (rid !== 1'b0) begin errors++; $display("[TB] FAIL add_id got %b expected 0", rid); end
    checks++; if (rdz !== 1'b0) begin errors++; $display("[TB] FAIL add_dz got %b expected 0", rdz); end
    run_op(1'b0, OP_SUB, 32'd3, 32'd5, lat, rd, rid, rdz);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL sub_lat got %0d expected 1", lat); end
    checks++; if (rd !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL sub_rd got %h expected fffffffe", rd); end
  endtask

  task automatic test_mul_div();
    int lat; logic [31:0] rd; logic rid, rdz;
    idle_cycles(2);
    run_op(1'b1, OP_MUL, 32'h0001_0000, 32'h0001_0003, lat, rd, rid, rdz);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL mul_lat got %0d expected 2", lat); end
    checks++; if (rd !== 32'h0003_0000) begin errors++; $display("[TB] FAIL mul_rd got %h expected 00030000", rd); end
    checks++; if (rid !== 1'b1) begin errors++; $display("[TB] FAIL mul_id got %b expected 1", rid); end
    run_op(1'b1, OP_DIV, 32'd100, 32'd7, lat, rd, rid, rdz);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL div_lat got %0d expected 4", lat); end
    checks++; if (rd !== 32'd14) begin errors++; $display("[TB] FAIL div_rd got %h expected %h", rd, 32'd14); end
    checks++; if (rdz !== 1'b0) begin errors++; $display("[TB] FAIL div_dz got %b expected 0", rdz); end
  endtask

  task automatic test_round_robin();
    int g[8]; int gc[8]; int rid[8]; logic [31:0] rrd[8];
    int ng, nr;
    for (int i = 0; i < 8; i++) begin g[i] = -1; gc[i] = -100; rid[i] = -1; rrd[i] = 32'hDEAD_BEEF; end
    ng = 0; nr = 0;
    idle_cycles(2);
    bus.r0_op = OP_ADD; bus.r0_rs = 32'd1; bus.r0_rt = 32'd1;
    bus.r1_op = OP_ADD; bus.r1_rs = 32'd2; bus.r1_rt = 32'd2;
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    #1;
    for (int c = 0; c < 15; c++) begin
      if (bus.r0_ready && ng < 8) begin g[ng] = 0; gc[ng] = c; ng++; end
      if (bus.r1_ready && ng < 8) begin g[ng] = 1; gc[ng] = c; ng++; end
      if (bus.resp_valid && nr < 8) begin rid[nr] = int'(bus.resp_id); rrd[nr] = bus.resp_rd; nr++; end
      tick();
    end
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (g[i] !== (i % 2)) begin errors++; $display("[TB] FAIL rr_grant%0d got %0d expected %0d", i, g[i], i % 2); end
      checks++; if (rid[i] !== (i % 2)) begin errors++; $display("[TB] FAIL rr_id%0d got %0d expected %0d", i, rid[i], i % 2); end
      checks++; if (rrd[i] !== ((i % 2) ? 32'd4 : 32'd2)) begin errors++; $display("[TB] FAIL rr_rd%0d got %h expected %h", i, rrd[i], (i % 2) ? 32'd4 : 32'd2); end
    end
    for (int i = 1; i < 4; i++) begin
      checks++; if (gc[i] - gc[i-1] !== 3) begin errors++; $display("[TB] FAIL rr_spacing%0d got %0d expected 3", i, gc[i] - gc[i-1]); end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] rd; logic rid, rdz;
    idle_cycles(2);
    run_op(1'b0, OP_DIV, 32'd9, 32'd0, lat, rd, rid, rdz);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL dz_lat got %0d expected 1", lat); end
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL dz_rd got %h expected ffffffff", rd); end
    checks++; if (rdz !== 1'b1) begin errors++; $display("[TB] FAIL dz_flag got %b expected 1", rdz); end
    run_op(1'b0, 4'b0000, 32'd2, 32'd2, lat, rd, rid, rdz);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL dflt_lat got %0d expected 1", lat); end
    checks++; if (rd !== 32'd4) begin errors++; $display("[TB] FAIL dflt_rd got %h expected %h", rd, 32'd4); end
    checks++; if (rdz !== 1'b0) begin errors++; $display("[TB] FAIL dflt_dz got %b expected 0", rdz); end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic rid, rdz;
    idle_cycles(2);
    bus.resp_ready = 1'b0;
    run_op(1'b1, OP_ADD, 32'd10, 32'd20, lat, rd, rid, rdz);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL bp_lat got %0d expected 1", lat); end
    bus.r0_valid = 1'b1; bus.r0_op = OP_ADD; bus.r0_rs = 32'd1; bus.r0_rt = 32'd1;
    bus.r1_valid = 1'b1; bus.r1_op = OP_ADD; bus.r1_rs = 32'd1; bus.r1_rt = 32'd1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid%0d got %b expected 1", k, bus.resp_valid); end
      checks++; if (bus.resp_rd !== 32'd30) begin errors++; $display("[TB] FAIL bp_rd%0d got %h expected %h", k, bus.resp_rd, 32'd30); end
      checks++; if (bus.resp_id !== 1'b1) begin errors++; $display("[TB] FAIL bp_id%0d got %b expected 1", k, bus.resp_id); end
      checks++; if (bus.resp_dz !== 1'b0) begin errors++; $display("[TB] FAIL bp_dz%0d got %b expected 0", k, bus.resp_dz); end
      checks++; if ({bus.r0_ready, bus.r1_ready} !== 2'b00) begin errors++; $display("[TB] FAIL bp_ready%0d got %b expected 00", k, {bus.r0_ready, bus.r1_ready}); end
      tick();
    end
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid got %b expected 0", bus.resp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    idle_cycles(2);
    bus.r0_valid = 1'b1; bus.r0_op = OP_DIV; bus.r0_rs = 32'd100; bus.r0_rt = 32'd5;
    #1;
    n = 0;
    while (!bus.r0_ready && n < 20) begin tick(); n++; end
    checks++; if (bus.r0_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_accept got %b expected 1", bus.r0_ready); end
    tick();
    bus.r0_valid = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy got %b expected 1", bus.busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy got %b expected 0", bus.busy); end
    checks++; if (bus.resp_rd !== 32'd0) begin errors++; $display("[TB] FAIL mid_rst_rd got %h expected 0", bus.resp_rd); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_noresp%0d got %b expected 0", k, bus.resp_valid); end
      tick();
    end
    bus.r0_valid = 1'b1; bus.r0_op = OP_ADD; bus.r0_rs = 32'd1; bus.r0_rt = 32'd1;
    bus.r1_valid = 1'b1; bus.r1_op = OP_ADD; bus.r1_rs = 32'd1; bus.r1_rt = 32'd1;
    #1;
    checks++; if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin errors++; $display("[TB] FAIL mid_tie_grant got %b expected 10", {bus.r0_ready, bus.r1_ready}); end
    idle_cycles(6);
  endtask

  initial begin
    $display("[TB] starting alu_sched bench");
    test_reset();
    test_add_sub();
    test_mul_div();
    test_round_robin();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Shared-ALU scheduler: arbitrates two requesters onto one instance of the team's 32-bit ALU (add/sub/mul/div), latches the operands, holds them stable for an op-dependent number of cycles so that mul/div can be constrained as multicycle paths, and returns a registered result through a valid/ready response port. It sits between the issue logic of two datapath clients and the ALU, and is the only block that drives the ALU inputs.

## Interface
- MUL_CYCLES, 2, cycles the operands are held for multiply (legal range 1..15)
- DIV_CYCLES, 4, cycles the operands are held for divide (legal range 1..15)
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- r0_valid  input  1  requester 0 has an operation
- r0_ready  output  1  requester 0 operation accepted this cycle
- r0_rs, r0_rt  input  32 each  requester 0 operands
- r0_op  input  4  requester 0 opcode
- r1_valid, r1_ready, r1_rs, r1_rt, r1_op: same as the r0 ports, for requester 1
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_rd  output  32  result
- resp_id  output  1  requester that issued the result
- resp_dz  output  1  divide by zero (result forced)
- busy  output  1  high in EXEC or DONE

## Operation
- Opcodes (one-hot): 4'b1000 add, 4'b0100 sub, 4'b0010 mul, 4'b0001 div. Any other code executes as add with add latency.
- Arithmetic is 32-bit unsigned and truncated: add/sub wrap mod 2^32, mul keeps the low 32 bits, div is the unsigned quotient.
- States: IDLE, EXEC, DONE.
- IDLE:
  - grant = the only valid requester; if both are valid, the requester not granted last (round-robin).
  - rX_ready = (state==IDLE) & rX_valid & grant==X. This path is combinational from valid.
  - On a handshake: latch rs, rt, op and id into operand registers, load cnt = hold_cycles-1, and go to EXEC.
  - The grantee is recorded in last_grant.
- hold_cycles is 1 for add/sub/default, MUL_CYCLES for mul, and DIV_CYCLES for div.
- Divide by zero (div with rt==0): hold_cycles = 1, resp_rd = 32'hFFFF_FFFF, resp_dz = 1. The ALU output is ignored.
- EXEC:
  - The operand registers drive the ALU and stay constant.
  - If cnt==0: capture the ALU result (or the forced value) into resp_rd, set resp_valid, and go to DONE. Otherwise decrement cnt.
- DONE:
  - resp_rd, resp_id and resp_dz are held stable while resp_valid=1 and resp_ready=0.
  - On resp_valid & resp_ready: clear resp_valid and go to IDLE.
- No request is accepted outside IDLE, and a valid requester is never dropped. A requester must hold its valid and operands until it sees ready.

## Timing
- Reset values:
  - state=IDLE, cnt=0, last_grant=1 (so requester 0 wins the first tie).
  - resp_valid=0, resp_rd=0, resp_id=0, resp_dz=0, busy=0.
  - r0_ready and r1_ready are 0 during reset.
- Reset mid-operation: an in-flight op or a pending result is discarded and no response is issued.
- Latency: for a handshake at cycle T, resp_valid rises at T+hold_cycles+1. This is T+2 for add/sub/default/div-by-zero, T+MUL_CYCLES+1 for mul, and T+DIV_CYCLES+1 for div.
- ALU inputs are stable from T+1 through the capture edge.
- Throughput:
  - With resp_ready tied high, DONE lasts 1 cycle and IDLE is re-entered at T+hold_cycles+2.
  - The next accept can occur in that same IDLE cycle, so an add costs 3 cycles per op.
- Backpressure: resp_ready low keeps the block in DONE indefinitely, with ready=0 to both requesters.
- resp_rd, resp_id and resp_dz change only on the capture edge and on reset.

## Test plan
- Reset for 2 cycles -> all outputs 0; after release with r0 and r1 idle, busy stays 0.
- r0 add rs=5, rt=7 accepted at T -> resp_valid at T+2 with rd=12, id=0, dz=0. Then r0 sub 3-5 -> rd=32'hFFFF_FFFE.
- r1 mul 32'h0001_0000 * 32'h0001_0003 with MUL_CYCLES=2 -> accepted at T, resp at T+3, rd=32'h0003_0000. Then div 100/7 with DIV_CYCLES=4 -> resp at T+5, rd=14.
- r0 and r1 both valid continuously with adds -> grants alternate 0,1,0,1; resp_id alternates accordingly; neither requester waits for more than one other op.
- div 9/0 -> resp at T+2 with rd=32'hFFFF_FFFF, dz=1; a following op 4'b0000 with 2+2 -> rd=4, dz=0.
- Response backpressure and reset:
  - Hold resp_ready=0 for 5 cycles -> resp fields stable, both readies 0; release -> IDLE the next cycle.
  - Assert reset during EXEC of a div -> no response; state is IDLE and last_grant=1 after reset.
